// File: rtl/serial_subtractor_pkg.sv
// serial_subtractor_pkg: shared FSM state encoding for the serial subtractor
package serial_subtractor_pkg;
    localparam int STATE_W = 2;
    typedef enum logic [STATE_W-1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;
endpackage

// File: rtl/serial_subtractor_if.sv
// serial_subtractor_if: start/ready/done handshake and operand/result bus
interface serial_subtractor_if #(parameter int WIDTH = 4);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             bin;
    logic             ready;
    logic             busy;
    logic [WIDTH-1:0] diff;
    logic             bout;
    logic             done;
    modport master (output start, a, b, bin, input ready, busy, diff, bout, done);
    modport slave  (input start, a, b, bin, output ready, busy, diff, bout, done);
endinterface

// File: rtl/serial_subtractor_full_subtractor.sv
// full_subtractor: one-bit x - y - bi with borrow-out
module full_subtractor (
    input  logic x,
    input  logic y,
    input  logic bi,
    output logic d,
    output logic bo
);
    assign d  = x ^ y ^ bi;
    assign bo = (~x & y) | (~(x ^ y) & bi);
endmodule

// File: rtl/serial_subtractor.sv
// serial_subtractor: bit-serial a - b - bin, LSB first, one bit per clock
module serial_subtractor
    import serial_subtractor_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input logic clk,
    input logic rst_n,
    serial_subtractor_if.slave io
);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);
    state_t           state;
    logic [WIDTH-1:0] sa, sb, sr, diff;
    logic [CNT_W-1:0] cnt;
    logic             br, bout, done, d, bo;
    full_subtractor u_fs (.x(sa[0]), .y(sb[0]), .bi(br), .d(d), .bo(bo));
    assign io.ready = state == ST_IDLE;
    assign io.busy  = state != ST_IDLE;
    assign io.diff  = diff;
    assign io.bout  = bout;
    assign io.done  = done;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
            sa    <= '0;
            sb    <= '0;
            sr    <= '0;
            br    <= 1'b0;
            cnt   <= '0;
            diff  <= '0;
            bout  <= 1'b0;
            done  <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: if (io.start) begin
                    sa    <= io.a;
                    sb    <= io.b;
                    br    <= io.bin;
                    cnt   <= '0;
                    state <= ST_SHIFT;
                end
                ST_SHIFT: begin
                    sa  <= sa >> 1;
                    sb  <= sb >> 1;
                    sr  <= {d, sr[WIDTH-1:1]};
                    br  <= bo;
                    cnt <= cnt + 1'b1;
                    if (cnt == LAST) begin
                        diff  <= {d, sr[WIDTH-1:1]};
                        bout  <= bo;
                        done  <= 1'b1;
                        state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    done  <= 1'b0;
                    state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_serial_subtractor.sv
// tb_serial_subtractor: randomized and exhaustive check against an integer model
module tb_serial_subtractor;
    localparam int W = 4;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int total = 0;
    int bad = 0;
    serial_subtractor_if #(.WIDTH(W)) io ();
    serial_subtractor #(.WIDTH(W)) dut (.clk(clk), .rst_n(rst_n), .io(io));
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [W:0] model(input logic [W-1:0] x, input logic [W-1:0] y, input logic c);
        int r;
        r = int'(x) - int'(y) - int'(c);
        model = {r < 0 ? 1'b1 : 1'b0, W'(r & ((1 << W) - 1))};
    endfunction

    task automatic run(input logic [W-1:0] x, input logic [W-1:0] y, input logic c);
        int n;
        logic [W:0] prev, exp;
        exp = model(x, y, c);
        @(negedge clk);
        check("ready_idle", io.ready, 1);
        prev = {io.bout, io.diff};
        io.a = x; io.b = y; io.bin = c; io.start = 1'b1;
        @(negedge clk);
        io.a = W'($urandom); io.b = W'($urandom); io.bin = 1'($urandom);
        check("busy", io.busy, 1);
        n = 0;
        while (!io.done && n < 20) begin
            check("hold", {io.bout, io.diff}, prev);
            io.start = 1'($urandom);
            @(negedge clk);
            n++;
        end
        io.start = 1'b0;
        check("latency", n, W);
        check("result", {io.bout, io.diff}, exp);
        check("ready_done", io.ready, 0);
        @(negedge clk);
        check("done_pulse", io.done, 0);
        check("ready_back", io.ready, 1);
        check("busy_back", io.busy, 0);
        check("keep", {io.bout, io.diff}, exp);
    endtask

    task automatic stream(input logic [W-1:0] x0, input logic [W-1:0] y0,
                          input logic [W-1:0] x1, input logic [W-1:0] y1);
        int n;
        logic pr;
        logic [W:0] e0, e1;
        e0 = model(x0, y0, 1'b0);
        e1 = model(x1, y1, 1'b0);
        @(negedge clk);
        check("s_ready", io.ready, 1);
        io.a = x0; io.b = y0; io.bin = 1'b0; io.start = 1'b1;
        @(negedge clk);
        io.a = x1; io.b = y1;
        n = 0;
        while (!io.done && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("s_lat0", n, W);
        check("s_res0", {io.bout, io.diff}, e0);
        pr = io.ready;
        n = 0;
        do begin
            @(negedge clk);
            n++;
            if (pr) io.start = 1'b0;
            pr = io.ready;
            if (!io.done) check("s_hold", {io.bout, io.diff}, e0);
        end while (!io.done && n < 20);
        io.start = 1'b0;
        check("s_period", n, W + 2);
        check("s_res1", {io.bout, io.diff}, e1);
        @(negedge clk);
        check("s_end", io.done, 0);
    endtask

    initial begin
        io.start = 1'b0; io.a = '0; io.b = '0; io.bin = 1'b0;
        #23;
        check("rst_ready", io.ready, 1);
        check("rst_busy", io.busy, 0);
        check("rst_out", {io.done, io.bout, io.diff}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        run(4'd9, 4'd3, 1'b0);
        run(4'd3, 4'd9, 1'b0);
        run(4'd0, 4'd0, 1'b1);
        run(4'd15, 4'd15, 1'b0);
        run(4'd9, 4'd3, 1'b0);
        @(negedge clk);
        io.a = 4'd9; io.b = 4'd3; io.start = 1'b1;
        @(negedge clk);
        io.start = 1'b0;
        @(negedge clk);
        #1 rst_n = 1'b0;
        #1;
        check("arst_ready", io.ready, 1);
        check("arst_busy", io.busy, 0);
        check("arst_out", {io.done, io.bout, io.diff}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        run(4'd5, 4'd2, 1'b0);
        stream(4'd9, 4'd3, 4'd1, 4'd1);
        stream(4'd7, 4'd1, 4'd1, 4'd7);
        for (int i = 0; i < 512; i++) run(W'(i >> 5), W'(i >> 1), 1'(i));
        for (int i = 0; i < 40; i++) run(W'($urandom), W'($urandom), 1'($urandom));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
